// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: the parallel side of the SPI shift engine.
//   load_valid/load_ready/data_in : transmit-word handshake (master -> engine)
//   data_out/data_out_valid       : last completed receive word
//   busy/done                     : transfer status; done is a one-cycle pulse
// The master modport belongs to the word producer/consumer.
// The slave modport belongs to the engine.
interface spi_shift_engine_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             data_out_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, data_in,
    input  load_ready, data_out, data_out_valid, busy, done
  );

  modport slave (
    input  load_valid, data_in,
    output load_ready, data_out, data_out_valid, busy, done
  );
endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: full-duplex SPI shift register for the LCD controller.
// A word accepted on the bus handshake is serialised on s_out. Bit timing
// comes from the external strobes: shift_en advances the transmit bit and
// sample_en captures shift_in into the receive word. The transfer completes
// on the WIDTH-th shift_en. At that point the receive word is published on
// bus.data_out and done pulses for one cycle.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : handshake, receive word and status (slave modport)
//   shift_en   : advance transmit bit (one-cycle strobe)
//   sample_en  : capture shift_in (one-cycle strobe)
//   shift_in   : serial receive data (MISO, already synchronised)
//   abort      : drop the current transfer without done
//   s_out      : serial transmit data (MOSI)
module spi_shift_engine #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_OUT  = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_shift_engine_if.slave   bus,
  input  logic                shift_en,
  input  logic                sample_en,
  input  logic                shift_in,
  input  logic                abort,
  output logic                s_out
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] tx_reg;
  logic [WIDTH-1:0] rx_reg;
  logic [WIDTH-1:0] rx_next;
  logic [WIDTH-1:0] tx_shifted;
  logic [WIDTH-1:0] data_out_reg;
  logic [CW-1:0]    count_reg;
  logic             done_reg;
  logic             data_out_valid_reg;
  logic             tx_bit;

  // The bit order only decides which end of the shift registers is active.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign tx_shifted = {1'b0, tx_reg[WIDTH-1:1]};
      assign tx_bit     = tx_reg[0];
    end else begin : g_msb
      assign tx_shifted = {tx_reg[WIDTH-2:0], 1'b0};
      assign tx_bit     = tx_reg[WIDTH-1];
    end
  endgenerate

  // rx_next includes a same-cycle sample. The completing edge can therefore
  // publish the final bit even when it coincides with the last shift.
  always_comb begin
    rx_next = rx_reg;
    if (sample_en) begin
      if (LSB_FIRST) rx_next = {shift_in, rx_reg[WIDTH-1:1]};
      else           rx_next = {rx_reg[WIDTH-2:0], shift_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg          <= IDLE;
      tx_reg             <= '0;
      rx_reg             <= '0;
      data_out_reg       <= '0;
      count_reg          <= '0;
      done_reg           <= 1'b0;
      data_out_valid_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.load_valid) begin
            tx_reg             <= bus.data_in;
            rx_reg             <= '0;
            count_reg          <= '0;
            data_out_valid_reg <= 1'b0;
            state_reg          <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (abort) begin
            state_reg <= IDLE;
          end else begin
            rx_reg <= rx_next;
            if (shift_en) begin
              tx_reg    <= tx_shifted;
              count_reg <= count_reg + 1'b1;
              if (count_reg == CW'(WIDTH - 1)) begin
                state_reg          <= IDLE;
                data_out_reg       <= rx_next;
                data_out_valid_reg <= 1'b1;
                done_reg           <= 1'b1;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // In the done cycle the state is already IDLE. A back-to-back load is
  // therefore accepted with no dead cycle.
  assign bus.load_ready     = (state_reg == IDLE);
  assign bus.busy           = (state_reg == ACTIVE);
  assign bus.done           = done_reg;
  assign bus.data_out       = data_out_reg;
  assign bus.data_out_valid = data_out_valid_reg;
  assign s_out              = (state_reg == ACTIVE) ? tx_bit : IDLE_OUT;
endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine with three instances:
//   dut0: WIDTH=8,  MSB-first, IDLE_OUT=0
//   dut1: WIDTH=8,  LSB-first, IDLE_OUT=1
//   dut2: WIDTH=16, MSB-first, IDLE_OUT=0
// A transfer-level model predicts every output. A negedge process compares
// the outputs against that model. Directed steps add literal expectations
// that pin the model.
module tb_spi_shift_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  lv, sh, sa, sin, ab;
  logic [31:0] din [3];
  logic        so0, so1, so2;
  wire  [2:0]  so = {so2, so1, so0};

  int n_tests = 0;
  int n_fail  = 0;

  spi_shift_engine_if #(.WIDTH(8))  if0 ();
  spi_shift_engine_if #(.WIDTH(8))  if1 ();
  spi_shift_engine_if #(.WIDTH(16)) if2 ();

  assign if0.load_valid = lv[0];
  assign if0.data_in    = din[0][7:0];
  assign if1.load_valid = lv[1];
  assign if1.data_in    = din[1][7:0];
  assign if2.load_valid = lv[2];
  assign if2.data_in    = din[2][15:0];

  spi_shift_engine #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_OUT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .shift_en(sh[0]), .sample_en(sa[0]),
    .shift_in(sin[0]), .abort(ab[0]), .s_out(so0));
  spi_shift_engine #(.WIDTH(8), .LSB_FIRST(1'b1), .IDLE_OUT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .shift_en(sh[1]), .sample_en(sa[1]),
    .shift_in(sin[1]), .abort(ab[1]), .s_out(so1));
  spi_shift_engine #(.WIDTH(16), .LSB_FIRST(1'b0), .IDLE_OUT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .shift_en(sh[2]), .sample_en(sa[2]),
    .shift_in(sin[2]), .abort(ab[2]), .s_out(so2));

  // Gathered DUT outputs, so the checks can loop over the instances.
  logic [31:0] dout_a [3];
  logic [2:0]  lr, bz, dn, dv;
  assign dout_a[0] = {24'd0, if0.data_out};
  assign dout_a[1] = {24'd0, if1.data_out};
  assign dout_a[2] = {16'd0, if2.data_out};
  assign lr = {if2.load_ready, if1.load_ready, if0.load_ready};
  assign bz = {if2.busy, if1.busy, if0.busy};
  assign dn = {if2.done, if1.done, if0.done};
  assign dv = {if2.data_out_valid, if1.data_out_valid, if0.data_out_valid};

  function automatic int wid(int i);
    return (i == 2) ? 16 : 8;
  endfunction
  function automatic bit lsbf(int i);
    return (i == 1);
  endfunction
  function automatic bit idl(int i);
    return (i == 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Transfer-level model. A word is in flight or not. k counts the bits
  // already shifted out. The receive word is rebuilt from the sampled bits.
  bit          m_act  [3];
  bit          m_dv   [3];
  bit          m_done [3];
  int          m_k    [3];
  logic [31:0] m_word [3];
  logic [31:0] m_rx   [3];
  logic [31:0] m_dout [3];

  always @(posedge clk or negedge rst_n) begin
    int w;
    logic [31:0] mask;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_act[i] = 0; m_dv[i] = 0; m_done[i] = 0; m_k[i] = 0;
        m_word[i] = 0; m_rx[i] = 0; m_dout[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        w = wid(i);
        mask = (32'd1 << w) - 32'd1;
        m_done[i] = 0;
        if (!m_act[i]) begin
          if (lv[i]) begin
            m_act[i] = 1; m_word[i] = din[i]; m_k[i] = 0; m_rx[i] = 0; m_dv[i] = 0;
          end
        end else if (ab[i]) begin
          m_act[i] = 0;
        end else begin
          if (sa[i]) begin
            if (lsbf(i)) m_rx[i] = (m_rx[i] >> 1) | ({31'd0, sin[i]} << (w - 1));
            else         m_rx[i] = ((m_rx[i] << 1) | {31'd0, sin[i]}) & mask;
          end
          if (sh[i]) begin
            if (m_k[i] == w - 1) begin
              m_act[i] = 0; m_dout[i] = m_rx[i]; m_dv[i] = 1; m_done[i] = 1;
            end else begin
              m_k[i]++;
            end
          end
        end
      end
    end
  end

  function automatic logic exp_so(int i);
    if (!m_act[i]) return idl(i);
    if (lsbf(i)) return m_word[i][m_k[i]];
    return m_word[i][wid(i) - 1 - m_k[i]];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("dut%0d.load_ready", i), lr[i], !m_act[i]);
        chk($sformatf("dut%0d.busy", i), bz[i], m_act[i]);
        chk($sformatf("dut%0d.done", i), dn[i], m_done[i]);
        chk($sformatf("dut%0d.s_out", i), so[i], exp_so(i));
        chk($sformatf("dut%0d.data_out", i), dout_a[i], m_dout[i]);
        chk($sformatf("dut%0d.data_out_valid", i), dv[i], m_dv[i]);
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int i, logic [31:0] w);
    lv[i] = 1'b1; din[i] = w;
    step();
    lv[i] = 1'b0;
    $display("[TB] dut%0d load %0h", i, w);
  endtask

  // Drives bits [start, start+n) of rxw in the instance's bit order. Each
  // bit is a sample cycle then a shift cycle, or one coincident cycle.
  // Also records s_out before each shift.
  bit so_q[$];
  task automatic run_bits(int i, logic [31:0] rxw, int start, int n, bit coinc);
    for (int b = start; b < start + n; b++) begin
      so_q.push_back(so[i]);
      sin[i] = lsbf(i) ? rxw[b] : rxw[wid(i) - 1 - b];
      sa[i] = 1'b1;
      if (coinc) sh[i] = 1'b1;
      step();
      sa[i] = 1'b0; sh[i] = 1'b0;
      if (!coinc) begin
        sh[i] = 1'b1;
        step();
        sh[i] = 1'b0;
      end
    end
    $display("[TB] dut%0d shifted %0d bits, rx pattern %0h", i, n, rxw);
  endtask

  initial begin
    bit e1 [8];
    bit e2 [8];
    e1 = '{1, 0, 1, 1, 0, 0, 1, 0};
    e2 = '{0, 1, 0, 0, 1, 1, 0, 1};
    rst_n = 1'b0; lv = '0; sh = '0; sa = '0; sin = '0; ab = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    #12 rst_n = 1'b1;
    #1;
    chk("reset.load_ready", lr, 3'b111);
    chk("reset.busy", bz, 3'b000);
    chk("reset.done", dn, 3'b000);
    chk("reset.valid", dv, 3'b000);
    chk("reset.s_out", so, 3'b010);
    step();

    // Basic MSB-first transfer.
    load(0, 32'hB2);
    so_q.delete();
    run_bits(0, 32'h3C, 0, 8, 1'b0);
    for (int b = 0; b < 8; b++) chk($sformatf("t1.s_out[%0d]", b), so_q[b], e1[b]);
    chk("t1.done", dn[0], 1'b1);
    chk("t1.busy", bz[0], 1'b0);
    chk("t1.data_out", dout_a[0], 32'h3C);
    chk("t1.valid", dv[0], 1'b1);
    step();
    chk("t1.done_width", dn[0], 1'b0);

    // LSB-first transfer.
    load(1, 32'hB2);
    so_q.delete();
    run_bits(1, 32'h3C, 0, 8, 1'b0);
    for (int b = 0; b < 8; b++) chk($sformatf("t2.s_out[%0d]", b), so_q[b], e2[b]);
    chk("t2.data_out", dout_a[1], 32'h3C);
    step();

    // Back-to-back loads, with load_valid held high throughout.
    lv[0] = 1'b1; din[0] = 32'h11;
    step();
    din[0] = 32'h22;
    run_bits(0, 32'h5A, 0, 8, 1'b0);
    chk("t3.done", dn[0], 1'b1);
    chk("t3.load_ready", lr[0], 1'b1);
    chk("t3.data_out", dout_a[0], 32'h5A);
    step();
    lv[0] = 1'b0;
    chk("t3.busy_again", bz[0], 1'b1);
    chk("t3.valid_cleared", dv[0], 1'b0);
    so_q.delete();
    run_bits(0, 32'hC3, 0, 8, 1'b0);
    chk("t3.second_tx_first_bit", so_q[0], 1'b0);
    chk("t3.second_tx_bit2", so_q[2], 1'b1);
    chk("t3.data_out2", dout_a[0], 32'hC3);
    step();

    // Abort after 3 shifts.
    load(0, 32'h77);
    run_bits(0, 32'h00, 0, 3, 1'b0);
    ab[0] = 1'b1;
    step();
    ab[0] = 1'b0;
    chk("t4.abort_busy", bz[0], 1'b0);
    chk("t4.abort_done", dn[0], 1'b0);
    chk("t4.abort_data_out", dout_a[0], 32'hC3);
    step();
    chk("t4.abort_no_done", dn[0], 1'b0);

    // Coincident strobes, LSB-first, shift_in = 1.
    load(1, 32'h5A);
    run_bits(1, 32'hFF, 0, 8, 1'b1);
    chk("t6.done", dn[1], 1'b1);
    chk("t6.data_out", dout_a[1], 32'hFF);
    step();

    // Wide word: idle strobes first, then a loopback with loads during ACTIVE.
    sh[2] = 1'b1; sa[2] = 1'b1; sin[2] = 1'b1;
    step();
    sh[2] = 1'b0; sa[2] = 1'b0;
    chk("t5.idle_busy", bz[2], 1'b0);
    chk("t5.idle_data_out", dout_a[2], 32'h0);
    load(2, 32'hA5C3);
    lv[2] = 1'b1; din[2] = 32'h1234;
    run_bits(2, 32'hA5C3, 0, 8, 1'b0);
    lv[2] = 1'b0;
    run_bits(2, 32'hA5C3, 8, 8, 1'b0);
    chk("t5.done", dn[2], 1'b1);
    chk("t5.data_out", dout_a[2], 32'hA5C3);
    chk("t5.valid", dv[2], 1'b1);
    step();

    // Reset after 5 shifts; outputs must clear with no clock edge.
    load(0, 32'h77);
    run_bits(0, 32'h00, 0, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t4.rst_busy", bz[0], 1'b0);
    chk("t4.rst_load_ready", lr[0], 1'b1);
    chk("t4.rst_done", dn[0], 1'b0);
    chk("t4.rst_valid", dv, 3'b000);
    chk("t4.rst_data_out", dout_a[0], 32'h0);
    chk("t4.rst_s_out", so, 3'b010);
    #1 rst_n = 1'b1;
    $display("[TB] reset released");
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
